// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath width, reset vector, canonical NOP, fetch entry layout.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_pkg;

  localparam int XLEN = 32;

  // PC fetched first after reset; must be word aligned.
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // addi x0, x0, 0 -- decode substitutes this when it kills a slot.
  localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;

  // One fetched instruction together with the address it came from.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/ifu_fifo.sv
// Small circular buffer holding fetched {pc, instr} entries between the BRAM and decode.
// Latency: a pushed entry is visible at head the cycle after the push edge; no fall-through.
// Backpressure: none internally; the caller reserves space before pushing. flush overrides push/pop.
// Ports: push/push_dat write at tail, pop advances head, flush empties, count = occupancy, head = oldest entry.
module ifu_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 64,
  localparam int CW   = $clog2(DEPTH + 1),
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  push_dat,
  input  logic          pop,
  input  logic          flush,
  output logic [CW-1:0] count,
  output logic [W-1:0]  head
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [PW-1:0] rd_q, rd_d;
  logic [PW-1:0] wr_q, wr_d;
  logic [CW-1:0] count_q, count_d;

  // Pointers wrap at DEPTH so non power-of-two depths also work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    mem_d   = mem_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    count_d = count_q;
    if (flush) begin
      rd_d    = '0;
      wr_d    = '0;
      count_d = '0;
    end else begin
      if (push) begin
        mem_d[wr_q] = push_dat;
        wr_d        = ptr_inc(wr_q);
      end
      if (pop) begin
        rd_d = ptr_inc(rd_q);
      end
      // Simultaneous push and pop on a full buffer leaves count unchanged.
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q   <= '{default: '0};
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign head  = mem_q[rd_q];

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, addresses BRAM port a, and hands {pc, instr} to decode.
// Latency: address issued in cycle T appears on if_* in cycle T+2; 1 instr/cycle sustained.
// Backpressure: if_ready low stalls issue once buffered + in-flight entries reach FIFO_DEPTH.
// Ports: addra/douta = BRAM port a; redirect_valid/redirect_pc = flush + new PC;
//        if_valid/if_ready/if_pc/if_instr = decode handshake; fetch_count = completed handshakes.
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [XLEN-3:0] addra,
  input  logic [XLEN-1:0] douta,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_instr,
  output logic [XLEN-1:0] fetch_count
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  // PCs are kept as word addresses; the low two bits are always zero.
  logic [XLEN-3:0] pc_q, pc_d;
  logic [XLEN-3:0] inflight_pc_q, inflight_pc_d;
  logic            inflight_q, inflight_d;
  logic [XLEN-1:0] fetch_count_q, fetch_count_d;

  logic [CW-1:0]   fifo_count;
  fetch_entry_t    fifo_head;
  fetch_entry_t    fifo_push_dat;
  logic            fifo_push;
  logic            deq;
  logic            issue;
  logic [CW:0]     occupancy;
  logic            unused_redirect_lo;

  assign unused_redirect_lo = ^redirect_pc[1:0];

  // Redirect target goes straight to the BRAM so a redirect costs no address cycle.
  assign addra    = redirect_valid ? redirect_pc[XLEN-1:2] : pc_q;
  assign if_valid = (fifo_count != '0) & ~redirect_valid;
  assign deq      = if_valid & if_ready;

  // Space accounting includes the read already in flight, so a return never
  // lands on a full buffer.
  assign occupancy = {1'b0, fifo_count} + (CW+1)'(inflight_q) - (CW+1)'(deq);
  assign issue     = redirect_valid | (occupancy < (CW+1)'(FIFO_DEPTH));

  // A return landing in the redirect cycle belongs to the old stream: drop it.
  assign fifo_push     = inflight_q & ~redirect_valid;
  assign fifo_push_dat = {inflight_pc_q, 2'b00, douta};

  always_comb begin
    pc_d          = pc_q;
    inflight_d    = issue;
    inflight_pc_d = inflight_pc_q;
    if (issue) begin
      pc_d          = addra + (XLEN-2)'(1);
      inflight_pc_d = addra;
    end
    fetch_count_d = fetch_count_q + XLEN'(deq);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC[XLEN-1:2];
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      fetch_count_q <= '0;
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  ifu_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (2 * XLEN)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (fifo_push),
    .push_dat (fifo_push_dat),
    .pop      (deq),
    .flush    (redirect_valid),
    .count    (fifo_count),
    .head     (fifo_head)
  );

  assign if_pc       = fifo_head.pc;
  assign if_instr    = fifo_head.instr;
  assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;
  import cpu_pkg::*;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [29:0] addra;
  logic [31:0] douta;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic [31:0] fetch_count;

  instr_fetch_unit #(.RESET_PC(32'h0), .FIFO_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .addra          (addra),
    .douta          (douta),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_pc          (if_pc),
    .if_instr       (if_instr),
    .fetch_count    (fetch_count)
  );

  always #5 clk = ~clk;

  // BRAM model: 256 words, 1-cycle read, zero outside range.
  logic [31:0] mem [256];
  always @(posedge clk) douta <= (addra < 30'd256) ? mem[addra[7:0]] : 32'h0;

  function automatic logic [31:0] exp_instr(input logic [31:0] pc);
    logic [29:0] w;
    w = pc[31:2];
    return (w < 30'd256) ? 32'hA000_0000 + {24'h0, w[7:0]} : 32'h0;
  endfunction

  int          tests = 0;
  int          fails = 0;
  int          hs_seen = 0;
  bit          sb_en = 1'b0;
  logic [31:0] exp_q [$];
  logic [31:0] model_next;

  task automatic sb_fill();
    while (exp_q.size() < 4) begin
      exp_q.push_back(model_next);
      model_next = model_next + 32'd4;
    end
  endtask

  task automatic sb_restart(input logic [31:0] pc);
    exp_q.delete();
    model_next = {pc[31:2], 2'b00};
    sb_fill();
  endtask

  // Scoreboard: every handshake must deliver the next expected pc/instr.
  always @(negedge clk) begin
    logic [31:0] e;
    if (sb_en && rst_n && if_valid && if_ready) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL sb_underflow: got pc=%h, no entry expected", if_pc);
      end else begin
        e = exp_q.pop_front();
        if (if_pc !== e || if_instr !== exp_instr(e)) begin
          fails++;
          $display("FAIL sb_data: got pc=%h instr=%h, expected pc=%h instr=%h",
                   if_pc, if_instr, e, exp_instr(e));
        end
      end
      hs_seen++;
      sb_fill();
    end
  end

  task automatic drive_redirect(input logic [31:0] pc);
    @(posedge clk); #1;
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    sb_restart(pc);
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests++;
    if (if_valid !== 1'b0 || if_pc !== 32'h0 || if_instr !== 32'h0 ||
        fetch_count !== 32'h0 || addra !== 30'h0) begin
      fails++;
      $display("FAIL reset_state: valid=%b pc=%h instr=%h cnt=%0d addra=%h, expected all zero",
               if_valid, if_pc, if_instr, fetch_count, addra);
    end
  endtask

  task automatic test_stream();
    if_ready = 1'b1;
    sb_restart(32'h0);
    sb_en = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k <= 12; k++) begin
      @(negedge clk);
      if (k < 6) begin
        tests++;
        if (addra !== 30'(k)) begin
          fails++;
          $display("FAIL stream_addra: cycle %0d addra=%h, expected %h", k, addra, 30'(k));
        end
      end
      tests++;
      if (if_valid !== (k >= 2)) begin
        fails++;
        $display("FAIL stream_valid: cycle %0d if_valid=%b, expected %b", k, if_valid, (k >= 2));
      end
      if (k == 12) begin
        tests++;
        if (fetch_count !== 32'd10) begin
          fails++;
          $display("FAIL stream_count: fetch_count=%0d, expected 10", fetch_count);
        end
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] hp, hi;
    @(posedge clk); #1;
    if_ready = 1'b0;
    @(negedge clk);
    hp = if_pc;
    hi = if_instr;
    tests++;
    if (if_valid !== 1'b1 || hp !== exp_q[0]) begin
      fails++;
      $display("FAIL stall_head: valid=%b pc=%h, expected 1 %h", if_valid, hp, exp_q[0]);
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      tests++;
      if (if_valid !== 1'b1 || if_pc !== hp || if_instr !== hi) begin
        fails++;
        $display("FAIL stall_frozen: cycle %0d valid=%b pc=%h instr=%h, expected 1 %h %h",
                 k, if_valid, if_pc, if_instr, hp, hi);
      end
      tests++;
      if ((addra - hp[31:2]) > 30'(DEPTH)) begin
        fails++;
        $display("FAIL stall_addra: addra=%h head word=%h, expected at most %0d ahead",
                 addra, hp[31:2], DEPTH);
      end
    end
    @(posedge clk); #1;
    if_ready = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_redirect();
    drive_redirect(32'h40);
    @(negedge clk);
    tests++;
    if (addra !== 30'h10 || if_valid !== 1'b0) begin
      fails++;
      $display("FAIL redir_same_cycle: addra=%h valid=%b, expected 10 0", addra, if_valid);
    end
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    @(negedge clk);
    tests++;
    if (if_valid !== 1'b0) begin
      fails++;
      $display("FAIL redir_r1: if_valid=%b, expected 0", if_valid);
    end
    @(negedge clk);
    tests++;
    if (if_valid !== 1'b1 || if_pc !== 32'h40) begin
      fails++;
      $display("FAIL redir_r2: valid=%b pc=%h, expected 1 00000040", if_valid, if_pc);
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_redirect_stall();
    @(posedge clk); #1;
    if_ready = 1'b0;
    repeat (4) @(negedge clk);
    drive_redirect(32'h103);
    @(negedge clk);
    tests++;
    if (addra !== 30'h40 || if_valid !== 1'b0) begin
      fails++;
      $display("FAIL rstall_addr: addra=%h valid=%b, expected 40 0", addra, if_valid);
    end
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    @(negedge clk);
    tests++;
    if (if_valid !== 1'b0) begin
      fails++;
      $display("FAIL rstall_flushed: if_valid=%b, expected 0", if_valid);
    end
    @(negedge clk);
    tests++;
    if (if_valid !== 1'b1 || if_pc !== 32'h100 || if_instr !== exp_instr(32'h100)) begin
      fails++;
      $display("FAIL rstall_out: valid=%b pc=%h instr=%h, expected 1 00000100 %h",
               if_valid, if_pc, if_instr, exp_instr(32'h100));
    end
    tests++;
    if (fetch_count !== 32'(hs_seen)) begin
      fails++;
      $display("FAIL rstall_count: fetch_count=%0d, expected %0d", fetch_count, hs_seen);
    end
    @(posedge clk); #1;
    if_ready = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    drive_redirect(32'h20);
    drive_redirect(32'h80);
    @(negedge clk);
    tests++;
    if (addra !== 30'h20 || if_valid !== 1'b0) begin
      fails++;
      $display("FAIL b2b_addr: addra=%h valid=%b, expected 20 0", addra, if_valid);
    end
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    @(negedge clk);
    tests++;
    if (if_valid !== 1'b0) begin
      fails++;
      $display("FAIL b2b_r1: if_valid=%b, expected 0", if_valid);
    end
    @(negedge clk);
    tests++;
    if (if_valid !== 1'b1 || if_pc !== 32'h80) begin
      fails++;
      $display("FAIL b2b_out: valid=%b pc=%h, expected 1 00000080", if_valid, if_pc);
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_wrap();
    drive_redirect(32'hFFFF_FFF8);
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    tests++;
    if (if_pc !== 32'hFFFF_FFF8 || if_instr !== 32'h0) begin
      fails++;
      $display("FAIL wrap_out: pc=%h instr=%h, expected fffffff8 00000000", if_pc, if_instr);
    end
    repeat (5) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    tests++;
    if (if_valid !== 1'b1) begin
      fails++;
      $display("FAIL rmid_pre: if_valid=%b, expected 1", if_valid);
    end
    @(posedge clk); #3;
    rst_n = 1'b0;
    sb_restart(32'h0);
    hs_seen = 0;
    #1;
    tests++;
    if (if_valid !== 1'b0 || fetch_count !== 32'h0 || addra !== 30'h0 || if_pc !== 32'h0) begin
      fails++;
      $display("FAIL rmid_async: valid=%b cnt=%0d addra=%h pc=%h, expected all zero",
               if_valid, fetch_count, addra, if_pc);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k < 3) begin
        tests++;
        if (addra !== 30'(k) || if_valid !== (k >= 2)) begin
          fails++;
          $display("FAIL rmid_restart: cycle %0d addra=%h valid=%b, expected %h %b",
                   k, addra, if_valid, 30'(k), (k >= 2));
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'hA000_0000 + 32'(i);
    rst_n          = 1'b0;
    if_ready       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_redirect_stall();
    test_back_to_back();
    test_wrap();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
